instr_feeder: RTL and testbench
===============================

Name: instr_feeder

Overview:
- Upstream stage of the 8-bit mini-RISC core. A host pushes instruction bytes, little-endian, lower byte first.
- The block assembles the bytes into 16-bit words and buffers them in a DEPTH-entry FIFO.
- It replays each word into the core's two-beat load protocol, then gives one execute cycle.
- The core's ui byte carries the load strobe on bit 7, so that bit is shared between strobe and instruction bit 7.

Parameters:
- DEPTH, 8, number of 16-bit FIFO entries; power of two, minimum 2.
- GAP, 0, extra idle cycles inserted after each execute cycle (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  host byte valid
- wr_data  in  8  host byte
- wr_ready  out  1  host may push; 0 when FIFO full and the assembly latch holds a lower byte
- run  in  1  issue enable; 0 pauses only between instructions
- flush  in  1  synchronous clear of FIFO, assembly latch and sequencer
- core_ui  out  8  to core ui_in
- core_uio  out  8  to core uio_in
- busy  out  1  sequencer not in IDLE
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- bit7_clash  out  1  sticky; a queued word had bit 7 = 0

Behaviour:
- Reset values:
  - core_ui = 0, core_uio = 0, busy = 0, empty = 1, full = 0, level = 0, bit7_clash = 0, wr_ready = 1.
  - Assembly latch is cleared and the sequencer is in IDLE.
- Assembly:
  - A byte is accepted when wr_valid && wr_ready.
  - The first accepted byte goes to lo_latch and sets half = 1.
  - The second accepted byte forms the word {byte, lo_latch}, which is pushed to the FIFO; half returns to 0.
  - wr_ready = !(full && half), so a lower byte may be latched while the FIFO is full.
  - The push happens in the same cycle as the upper-byte acceptance.
  - If the pushed word has bit 7 = 0, bit7_clash is set. It clears only on rst or flush.
- FIFO:
  - Circular buffer with pointers wrapping modulo DEPTH.
  - level counts 0..DEPTH.
  - A simultaneous push and pop leaves level unchanged and is legal when full, because the pop frees the slot.
  - A pop when empty never occurs.
- Sequencer states: IDLE, SEND_LO, SEND_HI, EXEC, WAIT.
  - IDLE: core_ui = 0, core_uio = 0. If run && !empty, pop a word into cur and go to SEND_LO.
  - SEND_LO (1 cycle): core_ui = {1, cur[6:0]}, core_uio = 0. Go to SEND_HI.
  - SEND_HI (1 cycle): core_ui = 8'h80, core_uio = cur[15:8]. Go to EXEC.
  - EXEC (1 cycle): core_ui = 0, core_uio = 0; the core executes. If GAP = 0, behave as IDLE to select the next state; otherwise go to WAIT.
  - WAIT: hold zero outputs for GAP cycles via a 4-bit down-counter, then go to IDLE.
- Throughput and latency:
  - Back-to-back throughput with GAP = 0 is one instruction per 3 cycles.
  - Latency from the upper-byte push into an empty FIFO (run = 1, IDLE) to SEND_LO is 2 cycles: pop registered, then drive.
- Outputs: core_ui and core_uio are registered and glitch-free; they are never X after reset.
- run deassert: takes effect only in IDLE or EXEC; a started instruction always completes all 3 beats.
- flush:
  - Priority order is rst > flush > push/pop.
  - Flush forces IDLE, zero outputs, an empty FIFO and half = 0; a byte offered in the same cycle is dropped.
  - A flush mid-instruction truncates it. The core may then hold half a load; the host must reset the core.
- Reset mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro: INSTR_FEEDER_CNT_EN.
- Defined:
  - Adds output issued_cnt [7:0], incremented on every EXEC cycle and wrapping 255 -> 0.
  - Reset and flush clear it to 0.
- Undefined: the port is absent and no counter logic is present.

Test Plan:
- Single word, run = 1: push 8'hA1 then 8'h0C.
  - core_ui sequence: 00, A1, 80, 00 (SEND_LO at cycle +2 after the push).
  - core_uio = 0C during SEND_HI.
  - bit7_clash stays 0.
- Bit-7 clash: push 8'h21 then 8'h00.
  - bit7_clash = 1 at the push.
  - Driven lower byte is 8'hA1.
  - flush clears bit7_clash.
- Fill and full with run = 0, DEPTH = 8: push 16 bytes.
  - full = 1, level = 8.
  - A 17th byte is accepted (half = 1); the 18th sees wr_ready = 0.
  - Assert run: the first pop restores wr_ready; 9 instructions issue in FIFO order.
- Throughput and pause, GAP = 0 with 4 words queued: 12 cycles of continuous beats.
  - Drop run during a SEND_HI: the instruction completes, then IDLE.
  - With GAP = 3, 3 zero cycles appear between EXEC and the next SEND_LO.
- Reset mid-instruction: assert rst in SEND_LO.
  - Outputs go to 0 asynchronously, level = 0, empty = 1.
  - After release, new pushes issue normally.
- Counter wrap (with INSTR_FEEDER_CNT_EN): issue 257 instructions.
  - issued_cnt = 1.

Source files
------------

// File: rtl/instr_feeder.sv
// Byte assembler, 16-bit FIFO and two-beat load sequencer feeding the mini-RISC core.
// Define INSTR_FEEDER_CNT_EN to add the issued_cnt output (EXEC-cycle counter).
module instr_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    input  logic                   run,
    input  logic                   flush,
    output logic [7:0]             core_ui,
    output logic [7:0]             core_uio,
    output logic                   busy,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
`ifdef INSTR_FEEDER_CNT_EN
    output logic [7:0]             issued_cnt,
`endif
    output logic                   bit7_clash
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);
    localparam logic [3:0]  WaitLoad  = 4'(GAP - 1);

    typedef enum logic [2:0] {StIdle, StSendLo, StSendHi, StExec, StWait} state_e;

    state_e        state_q, state_d;
    logic [7:0]    ui_q, ui_d, uio_q, uio_d;
    logic [7:0]    hi_q, hi_d, lo_q, lo_d;
    logic          half_q, half_d, clash_q, clash_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [3:0]    wait_q, wait_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   head;
    logic          accept, push, pop, select;
`ifdef INSTR_FEEDER_CNT_EN
    logic [7:0]    cnt_q, cnt_d;
    assign issued_cnt = cnt_q;
`endif

    assign empty      = (level_q == '0);
    assign full       = (level_q == LevelFull);
    assign wr_ready   = !(full && half_q);
    assign busy       = (state_q != StIdle);
    assign level      = level_q;
    assign core_ui    = ui_q;
    assign core_uio   = uio_q;
    assign bit7_clash = clash_q;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        ui_d     = ui_q;
        uio_d    = uio_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        half_d   = half_q;
        clash_d  = clash_q;
        wait_d   = wait_q;
        pop      = 1'b0;
        select   = 1'b0;
        accept   = wr_valid && wr_ready;
        push     = accept && half_q;
`ifdef INSTR_FEEDER_CNT_EN
        cnt_d    = (state_q == StExec) ? cnt_q + 8'd1 : cnt_q;
`endif
        if (accept) begin
            half_d = !half_q;
            if (!half_q) lo_d = wr_data;
        end
        if (push && !lo_q[7]) clash_d = 1'b1;

        case (state_q)
            StIdle:   select = 1'b1;
            StSendLo: begin
                state_d = StSendHi;
                ui_d    = 8'h80;
                uio_d   = hi_q;
            end
            StSendHi: begin
                state_d = StExec;
                ui_d    = '0;
                uio_d   = '0;
            end
            StExec: begin
                if (GAP == 0) begin
                    select = 1'b1;
                end else begin
                    state_d = StWait;
                    wait_d  = WaitLoad;
                    ui_d    = '0;
                    uio_d   = '0;
                end
            end
            StWait: begin
                if (wait_q == '0) select = 1'b1;
                else              wait_d = wait_q - 4'd1;
            end
            default: begin
                state_d = StIdle;
                ui_d    = '0;
                uio_d   = '0;
            end
        endcase

        // Last cycle of EXEC/WAIT decides like IDLE so the gap is exactly GAP cycles.
        if (select) begin
            state_d = StIdle;
            ui_d    = '0;
            uio_d   = '0;
            if (run && !empty) begin
                pop     = 1'b1;
                hi_d    = head[15:8];
                ui_d    = head[7:0] | 8'h80;
                state_d = StSendLo;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (flush) begin
            push     = 1'b0;
            pop      = 1'b0;
            state_d  = StIdle;
            ui_d     = '0;
            uio_d    = '0;
            hi_d     = '0;
            lo_d     = '0;
            half_d   = 1'b0;
            clash_d  = 1'b0;
            wait_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
`ifdef INSTR_FEEDER_CNT_EN
            cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ui_q     <= '0;
            uio_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            half_q   <= 1'b0;
            clash_q  <= 1'b0;
            wait_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef INSTR_FEEDER_CNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ui_q     <= ui_d;
            uio_q    <= uio_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            half_q   <= half_d;
            clash_q  <= clash_d;
            wait_q   <= wait_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
`ifdef INSTR_FEEDER_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_data, lo_q};
    end
endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed scenarios plus a randomized run
// scored against a queue model of the host byte stream and the core load protocol.
module tb_instr_feeder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, wr_valid, run, flush;
    logic [7:0]    wr_data;
    logic          wr_ready, busy, empty, full, bit7_clash;
    logic [7:0]    core_ui, core_uio;
    logic [LW-1:0] level;
    logic          g_wr_ready, g_busy, g_empty, g_full, g_clash;
    logic [7:0]    g_ui, g_uio;
    logic [LW-1:0] g_level;
`ifdef INSTR_FEEDER_CNT_EN
    logic [7:0]    issued_cnt, g_cnt;
`endif

    instr_feeder #(.DEPTH(DEPTH), .GAP(0)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .run(run), .flush(flush), .core_ui(core_ui), .core_uio(core_uio), .busy(busy),
        .empty(empty), .full(full), .level(level),
`ifdef INSTR_FEEDER_CNT_EN
        .issued_cnt(issued_cnt),
`endif
        .bit7_clash(bit7_clash)
    );

    instr_feeder #(.DEPTH(DEPTH), .GAP(3)) u_gap (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(g_wr_ready),
        .run(run), .flush(flush), .core_ui(g_ui), .core_uio(g_uio), .busy(g_busy),
        .empty(g_empty), .full(g_full), .level(g_level),
`ifdef INSTR_FEEDER_CNT_EN
        .issued_cnt(g_cnt),
`endif
        .bit7_clash(g_clash)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    // Protocol monitor: reconstructs issued words from the beats seen by the core.
    int          cyc, phase, mon_bad;
    logic [7:0]  prev_ui, mon_lo;
    logic [15:0] obs_q[$];
    int          lo_cyc_q[$];
    // Reference model of the host stream.
    logic [15:0] exp_q[$];
    logic        m_half, m_clash;
    logic [7:0]  m_lo;

    initial begin
        cyc = 0; phase = 0; mon_bad = 0; prev_ui = 8'h00; mon_lo = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || flush) begin
                phase = 0;
            end else begin
                case (phase)
                    0: begin
                        if (core_ui[7]) begin
                            if (prev_ui !== 8'h00 || core_uio !== 8'h00) mon_bad++;
                            mon_lo = core_ui;
                            lo_cyc_q.push_back(cyc);
                            phase = 1;
                        end else if (core_ui !== 8'h00 || core_uio !== 8'h00) begin
                            mon_bad++;
                        end
                    end
                    1: begin
                        if (core_ui !== 8'h80) mon_bad++;
                        obs_q.push_back({core_uio, mon_lo});
                        phase = 2;
                    end
                    default: begin
                        if (core_ui !== 8'h00 || core_uio !== 8'h00) mon_bad++;
                        phase = 0;
                    end
                endcase
            end
            prev_ui = core_ui;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        obs_q.delete();
        lo_cyc_q.delete();
        m_half  = 1'b0;
        m_clash = 1'b0;
        m_lo    = 8'h00;
    endtask

    task automatic m_accept(input logic [7:0] b);
        if (!m_half) begin
            m_lo   = b;
            m_half = 1'b1;
        end else begin
            exp_q.push_back({b, m_lo | 8'h80});
            if (!m_lo[7]) m_clash = 1'b1;
            m_half = 1'b0;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc = 1'b0;
        wr_valid = 1'b1;
        wr_data  = b;
        for (int k = 0; k < 400; k++) begin
            if (wr_ready) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
        if (acc) begin
            m_accept(b);
        end else begin
            n_checks++; n_err++;
            $display("FAIL push_timeout: byte %h never accepted, required acceptance", b);
        end
    endtask

    task automatic wait_obs(input int n, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (obs_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        n_checks++; if (core_ui !== 8'h00) begin n_err++; $display("FAIL rst_ui: got %h want 00", core_ui); end
        n_checks++; if (core_uio !== 8'h00) begin n_err++; $display("FAIL rst_uio: got %h want 00", core_uio); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
        n_checks++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_checks++; if (bit7_clash !== 1'b0) begin n_err++; $display("FAIL rst_clash: got %b want 0", bit7_clash); end
        n_checks++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
`ifdef INSTR_FEEDER_CNT_EN
        n_checks++; if (issued_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", issued_cnt); end
`endif
    endtask

    task automatic test_single();
        logic [7:0] want_ui[4] = '{8'h00, 8'hA1, 8'h80, 8'h00};
        run = 1'b1;
        push_byte(8'hA1);
        push_byte(8'h0C);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (core_ui !== want_ui[i]) begin
                n_err++; $display("FAIL single_ui[%0d]: got %h want %h", i, core_ui, want_ui[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (core_uio !== 8'h0C) begin n_err++; $display("FAIL single_uio: got %h want 0C", core_uio); end
            end
            tick();
        end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy %b want 0", busy); end
        n_checks++; if (bit7_clash !== 1'b0) begin n_err++; $display("FAIL single_clash: got %b want 0", bit7_clash); end
    endtask

    task automatic test_clash();
        do_flush();
        run = 1'b1;
        push_byte(8'h21);
        push_byte(8'h00);
        n_checks++; if (bit7_clash !== 1'b1) begin n_err++; $display("FAIL clash_set: got %b want 1", bit7_clash); end
        tick();
        n_checks++; if (core_ui !== 8'hA1) begin n_err++; $display("FAIL clash_lo: got %h want A1", core_ui); end
        tick();
        n_checks++; if (core_uio !== 8'h00) begin n_err++; $display("FAIL clash_hi: got %h want 00", core_uio); end
        tick(); tick();
        do_flush();
        n_checks++; if (bit7_clash !== 1'b0) begin n_err++; $display("FAIL clash_flush: got %b want 0", bit7_clash); end
    endtask

    task automatic test_fill();
        logic [7:0] b18;
        do_flush();
        run = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        n_checks++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_checks++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL fill_level: got %0d want %0d", level, DEPTH); end
        n_checks++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready16: got %b want 1", wr_ready); end
        push_byte(8'($urandom));
        n_checks++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready17: got %b want 0", wr_ready); end
        b18 = 8'($urandom);
        wr_valid = 1'b1; wr_data = b18;
        tick(); tick();
        wr_valid = 1'b0;
        n_checks++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL fill_hold: level %0d want %0d", level, DEPTH); end
        run = 1'b1;
        tick();
        n_checks++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_reopen: got %b want 1", wr_ready); end
        n_checks++; if (level !== LW'(DEPTH - 1)) begin n_err++; $display("FAIL fill_pop: level %0d want %0d", level, DEPTH - 1); end
        push_byte(b18);
        wait_obs(9, 100);
        n_checks++; if (obs_q.size() !== 9) begin n_err++; $display("FAIL fill_count: got %0d want 9", obs_q.size()); end
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_throughput();
        do_flush();
        run = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        run = 1'b1;
        wait_obs(4, 60);
        tick(); tick(); tick();
        n_checks++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL tput_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL tput_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < 4 && i < lo_cyc_q.size(); i++) begin
            n_checks++;
            if (lo_cyc_q[i] - lo_cyc_q[i-1] !== 3) begin
                n_err++; $display("FAIL tput_spacing[%0d]: got %0d want 3", i, lo_cyc_q[i] - lo_cyc_q[i-1]);
            end
        end
        run = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (lo_cyc_q.size() >= 5) break;
            tick();
        end
        tick();
        run = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b1 || core_ui !== 8'h00) begin
            n_err++; $display("FAIL pause_exec: busy %b ui %h want 1 00", busy, core_ui); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL pause_idle: busy %b want 0", busy); end
        tick(); tick();
        n_checks++; if (level !== LW'(1) || obs_q.size() !== 5) begin
            n_err++; $display("FAIL pause_hold: level %0d words %0d want 1 5", level, obs_q.size()); end
        run = 1'b1;
        wait_obs(6, 30);
        tick(); tick(); tick();
        for (int i = 4; i < 6 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pause_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (mon_bad !== 0) begin n_err++; $display("FAIL tput_protocol: %0d beat errors want 0", mon_bad); end
    endtask

    task automatic test_gap();
        logic [7:0] trace[16];
        int i0 = -1;
        int j  = -1;
        bit zeros = 1'b1;
        do_flush();
        run = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        run = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            trace[k] = g_ui;
        end
        for (int k = 0; k < 16; k++) if (i0 < 0 && trace[k][7]) i0 = k;
        if (i0 >= 0) begin
            for (int k = i0 + 2; k < 16; k++) if (j < 0 && trace[k][7] && trace[k-1] == 8'h00) j = k;
            for (int k = i0 + 2; k < i0 + 6 && k < 16; k++) if (trace[k] != 8'h00) zeros = 1'b0;
        end
        n_checks++; if (i0 < 0 || trace[i0] !== exp_q[0][7:0]) begin
            n_err++; $display("FAIL gap_first: index %0d want low byte %h", i0, exp_q[0][7:0]); end
        n_checks++; if (j - i0 !== 6) begin n_err++; $display("FAIL gap_spacing: got %0d want 6", j - i0); end
        n_checks++; if (!zeros) begin n_err++; $display("FAIL gap_zeros: nonzero beat in EXEC/WAIT window, want 00"); end
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_reset_mid();
        do_flush();
        run = 1'b1;
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        for (int k = 0; k < 20; k++) begin
            if (lo_cyc_q.size() >= 1) break;
            tick();
        end
        rst = 1'b1;
        #1;
        n_checks++; if (core_ui !== 8'h00 || core_uio !== 8'h00) begin
            n_err++; $display("FAIL rstmid_out: ui %h uio %h want 00 00", core_ui, core_uio); end
        n_checks++; if (level !== '0 || empty !== 1'b1) begin
            n_err++; $display("FAIL rstmid_fifo: level %0d empty %b want 0 1", level, empty); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tick();
        rst = 1'b0;
        model_clear();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_obs(1, 20);
        tick(); tick(); tick();
        n_checks++; if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL rstmid_after: words %0d first %h want 1 %h", obs_q.size(), obs_q[0], exp_q[0]); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit acc;
        do_flush();
        for (int it = 0; it < 400; it++) begin
            run = ($urandom_range(0, 3) != 0);
            acc = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                wr_valid = 1'b1; wr_data = b;
                acc = wr_ready;
            end
            tick();
            wr_valid = 1'b0;
            if (acc) m_accept(b);
        end
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (obs_q.size() >= exp_q.size() && !busy) break;
            tick();
        end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bit7_clash !== m_clash) begin n_err++; $display("FAIL rand_clash: got %b want %b", bit7_clash, m_clash); end
        n_checks++; if (empty !== 1'b1) begin n_err++; $display("FAIL rand_drain: empty %b want 1", empty); end
        n_checks++; if (mon_bad !== 0) begin n_err++; $display("FAIL rand_protocol: %0d beat errors want 0", mon_bad); end
    endtask

`ifdef INSTR_FEEDER_CNT_EN
    task automatic test_wrap();
        do_flush();
        run = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push_byte(8'($urandom) | 8'h80);
            push_byte(8'($urandom));
        end
        wait_obs(257, 2000);
        tick(); tick(); tick(); tick();
        n_checks++; if (obs_q.size() !== 257) begin n_err++; $display("FAIL wrap_count: got %0d want 257", obs_q.size()); end
        n_checks++; if (issued_cnt !== 8'(257 % 256)) begin
            n_err++; $display("FAIL wrap_cnt: got %0d want %0d", issued_cnt, 257 % 256); end
        do_flush();
        n_checks++; if (issued_cnt !== 8'd0) begin n_err++; $display("FAIL cnt_flush: got %0d want 0", issued_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; run = 1'b0; flush = 1'b0;
        model_clear();
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_single();
        test_clash();
        test_fill();
        test_throughput();
        test_gap();
        test_reset_mid();
        test_random();
`ifdef INSTR_FEEDER_CNT_EN
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
